// File: rtl/rf_wb_ctrl.sv
// Writeback controller for the dual-read register file: merges ALU and load results, tracks pending loads, bypasses reads.
// Optional feature: define RF_WB_R0_ZERO_EN to make register 0 a constant zero.
module rf_wb_ctrl #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_vld,
    output logic          alu_rdy,
    input  logic [AW-1:0] alu_reg,
    input  logic [DW-1:0] alu_data,
    input  logic          ld_vld,
    input  logic [AW-1:0] ld_reg,
    input  logic [DW-1:0] ld_data,
    input  logic          iss_vld,
    input  logic [AW-1:0] iss_reg,
    input  logic [AW-1:0] rd1sel,
    input  logic [AW-1:0] rd2sel,
    output logic          fwd1_hit,
    output logic [DW-1:0] fwd1_data,
    output logic          fwd2_hit,
    output logic [DW-1:0] fwd2_data,
    output logic          busy1,
    output logic          busy2,
    output logic          write,
    output logic [AW-1:0] writeregsel,
    output logic [DW-1:0] writedata,
    output logic          err
);
    localparam int NREG = 1 << AW;
`ifdef RF_WB_R0_ZERO_EN
    localparam logic R0Z = 1'b1;
`else
    localparam logic R0Z = 1'b0;
`endif

    logic [NREG-1:0] r_pend;
    logic            r_sb_vld;
    logic [AW-1:0]   r_sb_reg;
    logic [DW-1:0]   r_sb_data;
    logic            r_write;
    logic [AW-1:0]   r_wsel;
    logic [DW-1:0]   r_wdata;
    logic            r_err;

    logic            w_alu_acc;
    logic            w_win_vld;
    logic [AW-1:0]   w_win_reg;
    logic [DW-1:0]   w_win_data;
    logic            w_sb_load;
    logic            w_sb_clr;
    logic            w_ld_ok;
    logic            w_iss_ok;
    logic            w_err_set;
    logic [NREG-1:0] w_pend_nxt;
    logic [DW:0]     w_byp1;
    logic [DW:0]     w_byp2;

    function automatic logic [DW:0] bypass(
        input logic [AW-1:0] sel,
        input logic          sbv,
        input logic [AW-1:0] sbr,
        input logic [DW-1:0] sbd,
        input logic          wv,
        input logic [AW-1:0] wr,
        input logic [DW-1:0] wd
    );
        logic [DW:0] res;
        res = {(DW+1){1'b0}};
        if (R0Z && (sel == {AW{1'b0}})) begin
            res = {1'b1, {DW{1'b0}}};
        end else if (sbv && (sbr == sel)) begin
            res = {1'b1, sbd};
        end else if (wv && (wr == sel)) begin
            res = {1'b1, wd};
        end else begin
            res = {(DW+1){1'b0}};
        end
        return res;
    endfunction

    assign alu_rdy   = ~r_sb_vld;
    assign w_alu_acc = alu_vld & ~r_sb_vld;
    assign w_ld_ok   = ld_vld & ~(R0Z & (ld_reg == {AW{1'b0}}));
    assign w_iss_ok  = iss_vld & ~(R0Z & (iss_reg == {AW{1'b0}}));

    // Single write port: load beats the skid entry, which beats a fresh ALU result.
    always_comb begin
        w_win_vld  = 1'b0;
        w_win_reg  = {AW{1'b0}};
        w_win_data = {DW{1'b0}};
        w_sb_load  = 1'b0;
        w_sb_clr   = 1'b0;
        if (ld_vld) begin
            w_win_vld  = 1'b1;
            w_win_reg  = ld_reg;
            w_win_data = ld_data;
            w_sb_load  = w_alu_acc;
        end else if (r_sb_vld) begin
            w_win_vld  = 1'b1;
            w_win_reg  = r_sb_reg;
            w_win_data = r_sb_data;
            w_sb_clr   = 1'b1;
        end else if (w_alu_acc) begin
            w_win_vld  = 1'b1;
            w_win_reg  = alu_reg;
            w_win_data = alu_data;
        end else begin
            w_win_vld  = 1'b0;
        end
    end

    // Scoreboard update; a same-cycle issue overrides the clearing load.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_ld_ok) begin
            w_pend_nxt[ld_reg] = 1'b0;
        end else begin
            w_pend_nxt = r_pend;
        end
        if (w_iss_ok) begin
            w_pend_nxt[iss_reg] = 1'b1;
        end else begin
            w_pend_nxt[iss_reg] = w_pend_nxt[iss_reg];
        end
    end

    assign w_err_set = (w_ld_ok & ~r_pend[ld_reg])
                     | (w_iss_ok & r_pend[iss_reg] & ~(w_ld_ok & (ld_reg == iss_reg)))
                     | (w_alu_acc & r_pend[alu_reg])
                     | (w_ld_ok & w_alu_acc & (ld_reg == alu_reg));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend    <= {NREG{1'b0}};
            r_sb_vld  <= 1'b0;
            r_sb_reg  <= {AW{1'b0}};
            r_sb_data <= {DW{1'b0}};
            r_write   <= 1'b0;
            r_wsel    <= {AW{1'b0}};
            r_wdata   <= {DW{1'b0}};
            r_err     <= 1'b0;
        end else begin
            r_pend  <= w_pend_nxt;
            r_err   <= r_err | w_err_set;
            r_write <= w_win_vld & ~(R0Z & (w_win_reg == {AW{1'b0}}));
            r_wsel  <= w_win_reg;
            r_wdata <= w_win_data;
            if (w_sb_load) begin
                r_sb_vld  <= 1'b1;
                r_sb_reg  <= alu_reg;
                r_sb_data <= alu_data;
            end else if (w_sb_clr) begin
                r_sb_vld  <= 1'b0;
            end else begin
                r_sb_vld  <= r_sb_vld;
            end
        end
    end

    assign w_byp1    = bypass(rd1sel, r_sb_vld, r_sb_reg, r_sb_data, r_write, r_wsel, r_wdata);
    assign w_byp2    = bypass(rd2sel, r_sb_vld, r_sb_reg, r_sb_data, r_write, r_wsel, r_wdata);
    assign fwd1_hit  = w_byp1[DW];
    assign fwd1_data = w_byp1[DW-1:0];
    assign fwd2_hit  = w_byp2[DW];
    assign fwd2_data = w_byp2[DW-1:0];
    assign busy1     = r_pend[rd1sel] & ~(R0Z & (rd1sel == {AW{1'b0}}));
    assign busy2     = r_pend[rd2sel] & ~(R0Z & (rd2sel == {AW{1'b0}}));

    assign write       = r_write;
    assign writeregsel = r_wsel;
    assign writedata   = r_wdata;
    assign err         = r_err;
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Randomized self-checking bench for rf_wb_ctrl against a queue-based behavioural model.
module tb_rf_wb_ctrl;
`ifdef RF_WB_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_vld, alu_rdy, ld_vld, iss_vld;
    logic [2:0]  alu_reg, ld_reg, iss_reg, rd1sel, rd2sel, writeregsel;
    logic [15:0] alu_data, ld_data, fwd1_data, fwd2_data, writedata;
    logic        fwd1_hit, fwd2_hit, busy1, busy2, write, err;

    rf_wb_ctrl #(.DW(16), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_vld(alu_vld), .alu_rdy(alu_rdy), .alu_reg(alu_reg), .alu_data(alu_data),
        .ld_vld(ld_vld), .ld_reg(ld_reg), .ld_data(ld_data),
        .iss_vld(iss_vld), .iss_reg(iss_reg),
        .rd1sel(rd1sel), .rd2sel(rd2sel),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .busy1(busy1), .busy2(busy2),
        .write(write), .writeregsel(writeregsel), .writedata(writedata),
        .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct { logic [2:0] r; logic [15:0] d; } wr_t;
    bit   m_pend[8];
    wr_t  m_sb[$];
    bit   m_wr_v;
    wr_t  m_wr;
    bit   m_err;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit r0m(input logic [2:0] r);
        return R0Z && (r == 3'd0);
    endfunction

    function automatic logic [16:0] model_fwd(input logic [2:0] sel);
        if (r0m(sel)) return {1'b1, 16'h0000};
        if (m_sb.size() > 0 && m_sb[0].r == sel) return {1'b1, m_sb[0].d};
        if (m_wr_v && m_wr.r == sel) return {1'b1, m_wr.d};
        return 17'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
        m_sb.delete();
        m_wr_v = 1'b0;
        m_wr   = '{r: 3'd0, d: 16'd0};
        m_err  = 1'b0;
    endtask

    task automatic check_outputs();
        logic [16:0] f1, f2;
        f1 = model_fwd(rd1sel);
        f2 = model_fwd(rd2sel);
        check_val("alu_rdy",   alu_rdy,   m_sb.size() == 0);
        check_val("busy1",     busy1,     m_pend[rd1sel] && !r0m(rd1sel));
        check_val("busy2",     busy2,     m_pend[rd2sel] && !r0m(rd2sel));
        check_val("fwd1_hit",  fwd1_hit,  f1[16]);
        check_val("fwd1_data", fwd1_data, f1[15:0]);
        check_val("fwd2_hit",  fwd2_hit,  f2[16]);
        check_val("fwd2_data", fwd2_data, f2[15:0]);
        check_val("write",     write,     m_wr_v);
        if (m_wr_v) begin
            check_val("writeregsel", writeregsel, m_wr.r);
            check_val("writedata",   writedata,   m_wr.d);
        end
        check_val("err", err, m_err);
    endtask

    // Reference update from the current inputs, applied once per rising edge.
    task automatic model_update();
        bit  acc, ldok, issok, have;
        wr_t w;
        acc   = alu_vld && (m_sb.size() == 0);
        ldok  = ld_vld && !r0m(ld_reg);
        issok = iss_vld && !r0m(iss_reg);
        if (ldok && !m_pend[ld_reg]) m_err = 1'b1;
        if (issok && m_pend[iss_reg] && !(ldok && ld_reg == iss_reg)) m_err = 1'b1;
        if (acc && m_pend[alu_reg]) m_err = 1'b1;
        if (ldok && acc && ld_reg == alu_reg) m_err = 1'b1;
        have = 1'b0;
        w = '{r: 3'd0, d: 16'd0};
        if (ld_vld) begin
            have = 1'b1;
            w = '{r: ld_reg, d: ld_data};
            if (acc) m_sb.push_back('{r: alu_reg, d: alu_data});
        end else if (m_sb.size() > 0) begin
            have = 1'b1;
            w = m_sb.pop_front();
        end else if (acc) begin
            have = 1'b1;
            w = '{r: alu_reg, d: alu_data};
        end
        m_wr_v = have && !r0m(w.r);
        m_wr   = w;
        if (ldok) m_pend[ld_reg] = 1'b0;
        if (issok) m_pend[iss_reg] = 1'b1;
    endtask

    task automatic drive(input bit av, input logic [2:0] ar, input logic [15:0] ad,
                         input bit lv, input logic [2:0] lr, input logic [15:0] ld,
                         input bit iv, input logic [2:0] ir,
                         input logic [2:0] s1, input logic [2:0] s2);
        alu_vld = av; alu_reg = ar; alu_data = ad;
        ld_vld  = lv; ld_reg  = lr; ld_data  = ld;
        iss_vld = iv; iss_reg = ir;
        rd1sel  = s1; rd2sel  = s2;
        #1;
        check_outputs();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle(input logic [2:0] s1, input logic [2:0] s2);
        drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, s1, s2);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        alu_vld = 1'b0; ld_vld = 1'b0; iss_vld = 1'b0;
        alu_reg = 3'd0; ld_reg = 3'd0; iss_reg = 3'd0;
        alu_data = 16'd0; ld_data = 16'd0;
        rd1sel = 3'd1; rd2sel = 3'd2;
        #1;
        check_val("rst_write",   write,    1'b0);
        check_val("rst_alu_rdy", alu_rdy,  1'b1);
        check_val("rst_busy1",   busy1,    1'b0);
        check_val("rst_fwd1",    fwd1_hit, 1'b0);
        check_val("rst_fwd2",    fwd2_hit, 1'b0);
        check_val("rst_err",     err,      1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_cycle(input bit legal);
        bit av, lv, iv;
        logic [2:0] ar, lr, ir;
        int np;
        logic [2:0] pl[$];
        av = ($urandom_range(0, 9) < 6);
        lv = ($urandom_range(0, 9) < 4);
        iv = ($urandom_range(0, 9) < 4);
        ar = 3'($urandom_range(0, 7));
        lr = 3'($urandom_range(0, 7));
        ir = 3'($urandom_range(0, 7));
        if (legal) begin
            for (int i = 0; i < 8; i++) if (m_pend[i]) pl.push_back(3'(i));
            np = pl.size();
            if (lv && np > 0) lr = pl[$urandom_range(0, np - 1)];
            else lv = 1'b0;
            if (iv && m_pend[ir] && !(lv && lr == ir)) iv = 1'b0;
            if (av && (m_pend[ar] || (lv && lr == ar))) av = 1'b0;
        end
        drive(av, ar, 16'($urandom), lv, lr, 16'($urandom), iv, ir,
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        advance();
    endtask

    initial begin
        alu_vld = 1'b0; ld_vld = 1'b0; iss_vld = 1'b0;
        reset_pulse();

        // ALU result lands on the write port next cycle and is bypassed
        drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 3'd1, 3'd2);
        advance();
        idle(3'd3, 3'd2);
        check_val("t1_write", write, 1'b1);
        check_val("t1_wsel", writeregsel, 3'd3);
        check_val("t1_wdata", writedata, 16'h1234);
        check_val("t1_fwd1", {15'd0, fwd1_hit, fwd1_data}, {15'd0, 1'b1, 16'h1234});
        advance();

        // load beats ALU; ALU result waits in the skid buffer
        drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b1, 3'd2, 3'd1, 3'd1);
        advance();
        drive(1'b1, 3'd5, 16'h0005, 1'b1, 3'd2, 16'hBEEF, 1'b0, 3'd0, 3'd1, 3'd1);
        advance();
        idle(3'd1, 3'd5);
        check_val("t2_wsel_a", writeregsel, 3'd2);
        check_val("t2_wdata_a", writedata, 16'hBEEF);
        check_val("t2_rdy", alu_rdy, 1'b0);
        check_val("t2_fwd2", fwd2_data, 16'h0005);
        advance();
        idle(3'd1, 3'd1);
        check_val("t2_wsel_b", writeregsel, 3'd5);
        check_val("t2_wdata_b", writedata, 16'h0005);
        advance();

        // scoreboard set and clear
        drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b1, 3'd4, 3'd4, 3'd1);
        advance();
        drive(1'b0, 3'd0, 16'd0, 1'b1, 3'd4, 16'hAAAA, 1'b0, 3'd0, 3'd4, 3'd1);
        check_val("t3_busy_set", busy1, 1'b1);
        advance();
        idle(3'd4, 3'd1);
        check_val("t3_busy_clr", busy1, 1'b0);
        check_val("t3_err", err, 1'b0);
        advance();

        // unexpected load flags err but still writes
        drive(1'b0, 3'd0, 16'd0, 1'b1, 3'd6, 16'h6666, 1'b0, 3'd0, 3'd1, 3'd2);
        advance();
        idle(3'd1, 3'd2);
        check_val("t4_err", err, 1'b1);
        check_val("t4_wsel", writeregsel, 3'd6);
        advance();
        idle(3'd1, 3'd2);
        check_val("t4_err_sticky", err, 1'b1);

        // reset while the skid buffer is full
        drive(1'b1, 3'd7, 16'h7777, 1'b1, 3'd1, 16'h1111, 1'b0, 3'd0, 3'd1, 3'd2);
        advance();
        idle(3'd1, 3'd2);
        check_val("t5_sb_full", alu_rdy, 1'b0);
        reset_pulse();
        idle(3'd7, 3'd2);
        advance();
        idle(3'd7, 3'd2);
        check_val("t5_no_stray", write, 1'b0);
        advance();

`ifdef RF_WB_R0_ZERO_EN
        drive(1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 3'd0, 3'd1);
        advance();
        idle(3'd0, 3'd1);
        check_val("t6_write", write, 1'b0);
        check_val("t6_fwd1", {15'd0, fwd1_hit, fwd1_data}, {15'd0, 1'b1, 16'h0000});
        advance();
`endif

        for (int e = 0; e < 6; e++) begin
            reset_pulse();
            for (int c = 0; c < 120; c++) rand_cycle((e % 3) != 2);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
